// File: rtl/match_index_serializer_if.sv
// Mask-in / index-out handshake bundle for match_index_serializer.
// match_cnt is present only when MATCH_INDEX_SERIALIZER_COUNT_EN is defined.
interface match_index_serializer_if #(
  parameter int SIZE = 8
);
  localparam int IDXW = $clog2(SIZE);

  logic            mask_valid;
  logic            mask_ready;
  logic [SIZE-1:0] mask;
  logic            idx_valid;
  logic            idx_ready;
  logic [IDXW-1:0] idx;
  logic            idx_last;
  logic            none_pulse;
`ifdef MATCH_INDEX_SERIALIZER_COUNT_EN
  logic [IDXW:0]   match_cnt;
`endif

  // Upstream/downstream environment side.
  modport master (
    output mask_valid, mask, idx_ready,
    input  mask_ready, idx_valid, idx, idx_last, none_pulse
`ifdef MATCH_INDEX_SERIALIZER_COUNT_EN
    , input match_cnt
`endif
  );

  // Serializer side.
  modport slave (
    input  mask_valid, mask, idx_ready,
    output mask_ready, idx_valid, idx, idx_last, none_pulse
`ifdef MATCH_INDEX_SERIALIZER_COUNT_EN
    , output match_cnt
`endif
  );
endinterface

// File: rtl/match_index_serializer.sv
// Turns one SIZE-bit match mask into a lowest-first stream of set-bit indices.
// Optional popcount output enabled by MATCH_INDEX_SERIALIZER_COUNT_EN.
module match_index_serializer #(
  parameter int SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  match_index_serializer_if.slave bus
);
  localparam int IDXW = $clog2(SIZE);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SIZE-1:0] pend;
  logic            accept;
  logic            beat;
  logic            none_pulse_q;

  function automatic logic [IDXW-1:0] lowest_set(input logic [SIZE-1:0] v);
    lowest_set = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDXW'(i);
    end
  endfunction

  function automatic logic single_bit(input logic [SIZE-1:0] v);
    return (v != '0) && ((v & (v - SIZE'(1))) == '0);
  endfunction

  function automatic logic [IDXW:0] pop_count(input logic [SIZE-1:0] v);
    pop_count = '0;
    for (int i = 0; i < SIZE; i++) begin
      pop_count = pop_count + {{IDXW{1'b0}}, v[i]};
    end
  endfunction

  assign accept = (state == IDLE) && bus.mask_valid;
  assign beat   = (state == EMIT) && bus.idx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && (bus.mask != '0)) state_nxt = EMIT;
      EMIT: if (beat && single_bit(pend))   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mask_ready = (state == IDLE);
    bus.idx_valid  = (state == EMIT);
    bus.idx        = (state == EMIT) ? lowest_set(pend) : '0;
    bus.idx_last   = (state == EMIT) && single_bit(pend);
    bus.none_pulse = none_pulse_q;
  end

  // Clearing the lowest set bit retires exactly the index being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend         <= '0;
      none_pulse_q <= 1'b0;
    end else begin
      none_pulse_q <= accept && (bus.mask == '0);
      if (accept)    pend <= bus.mask;
      else if (beat) pend <= pend & (pend - SIZE'(1));
    end
  end

`ifdef MATCH_INDEX_SERIALIZER_COUNT_EN
  logic [IDXW:0] match_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      match_cnt_q <= '0;
    else if (accept) match_cnt_q <= pop_count(bus.mask);
  end

  assign bus.match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_match_index_serializer.sv
// Randomized and directed bench for match_index_serializer against a set-bit list model.
module tb_match_index_serializer;
  localparam int SIZE = 8;
  localparam int IDXW = $clog2(SIZE);

  typedef int idx_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  match_index_serializer_if #(.SIZE(SIZE)) bus ();

  match_index_serializer #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: every set bit, in ascending order.
  function automatic idx_q_t model_indices(input logic [SIZE-1:0] m);
    idx_q_t q;
    for (int i = 0; i < SIZE; i++) if (m[i]) q.push_back(i);
    return q;
  endfunction

  task automatic run_mask(input logic [SIZE-1:0] m, input int first_stall,
                          input int stall_pct, input string tag);
    idx_q_t exp;
    int budget, n, held, stall_run;
    logic rdy;
    exp = model_indices(m);
    bus.mask = m;
    bus.mask_valid = 1'b1;
    budget = 0;
    while (bus.mask_ready !== 1'b1 && budget < 50) begin
      step();
      budget++;
    end
    checks++;
    if (bus.mask_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout mask_ready=%b expected 1", tag, bus.mask_ready);
      bus.mask_valid = 1'b0;
      return;
    end
    step();
    bus.mask_valid = 1'b0;
    bus.mask = SIZE'($urandom);
`ifdef MATCH_INDEX_SERIALIZER_COUNT_EN
    checks++;
    if (bus.match_cnt !== (IDXW+1)'(exp.size())) begin
      errors++;
      $display("FAIL %s match_cnt got %0d expected %0d", tag, bus.match_cnt, exp.size());
    end
`endif
    if (exp.size() == 0) begin
      checks++;
      if (bus.none_pulse !== 1'b1 || bus.idx_valid !== 1'b0 || bus.mask_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s zero_accept none=%b valid=%b ready=%b expected 1 0 1",
                 tag, bus.none_pulse, bus.idx_valid, bus.mask_ready);
      end
      step();
      checks++;
      if (bus.none_pulse !== 1'b0 || bus.idx_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s none_width none=%b valid=%b expected 0 0", tag, bus.none_pulse, bus.idx_valid);
      end
    end else begin
      checks++;
      if (bus.none_pulse !== 1'b0) begin
        errors++;
        $display("FAIL %s none_on_nonzero got %b expected 0", tag, bus.none_pulse);
      end
      n = 0;
      held = 0;
      stall_run = 0;
      while (n < exp.size()) begin
        checks++;
        if (bus.idx_valid !== 1'b1 || bus.idx !== IDXW'(exp[n]) ||
            bus.idx_last !== logic'(n == exp.size() - 1) || bus.mask_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s beat%0d valid=%b idx=%0d last=%b ready=%b expected 1 %0d %b 0",
                   tag, n, bus.idx_valid, bus.idx, bus.idx_last, bus.mask_ready,
                   exp[n], (n == exp.size() - 1));
        end
        if (n == 0 && held < first_stall) begin
          rdy = 1'b0;
          held++;
        end else if (stall_run < 3 && int'($urandom_range(99)) < stall_pct) begin
          rdy = 1'b0;
        end else begin
          rdy = 1'b1;
        end
        stall_run = rdy ? 0 : stall_run + 1;
        bus.idx_ready = rdy;
        step();
        bus.mask = SIZE'($urandom);
        if (rdy) n++;
      end
      bus.idx_ready = 1'b1;
      checks++;
      if (bus.idx_valid !== 1'b0 || bus.mask_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s after_last valid=%b ready=%b expected 0 1", tag, bus.idx_valid, bus.mask_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.mask_ready !== 1'b1 || bus.idx_valid !== 1'b0 || bus.idx !== '0 ||
        bus.idx_last !== 1'b0 || bus.none_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_values ready=%b valid=%b idx=%0d last=%b none=%b expected 1 0 0 0 0",
               bus.mask_ready, bus.idx_valid, bus.idx, bus.idx_last, bus.none_pulse);
    end
`ifdef MATCH_INDEX_SERIALIZER_COUNT_EN
    checks++;
    if (bus.match_cnt !== '0) begin
      errors++;
      $display("FAIL reset_match_cnt got %0d expected 0", bus.match_cnt);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run_mask(8'b0010_0110, 0, 0, "three_bits");
    run_mask(8'b1000_0001, 3, 0, "stall_first");
    run_mask(8'h00, 0, 0, "zero_mask");
    run_mask(8'h08, 0, 0, "single_bit");
  endtask

  task automatic test_back_to_back();
    bus.mask = 8'hFF;
    bus.mask_valid = 1'b1;
    bus.idx_ready = 1'b1;
    checks++;
    if (bus.mask_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_ready got %b expected 1", bus.mask_ready);
    end
    step();
    bus.mask = 8'h10;
`ifdef MATCH_INDEX_SERIALIZER_COUNT_EN
    checks++;
    if (bus.match_cnt !== 4'd8) begin
      errors++;
      $display("FAIL b2b_match_cnt got %0d expected 8", bus.match_cnt);
    end
`endif
    for (int i = 0; i < SIZE; i++) begin
      checks++;
      if (bus.idx_valid !== 1'b1 || bus.idx !== IDXW'(i) || bus.idx_last !== logic'(i == SIZE - 1) ||
          bus.mask_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_full beat%0d valid=%b idx=%0d last=%b ready=%b expected 1 %0d %b 0",
                 i, bus.idx_valid, bus.idx, bus.idx_last, bus.mask_ready, i, (i == SIZE - 1));
      end
      step();
    end
    checks++;
    if (bus.mask_ready !== 1'b1 || bus.idx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap ready=%b valid=%b expected 1 0", bus.mask_ready, bus.idx_valid);
    end
    step();
    bus.mask_valid = 1'b0;
    checks++;
    if (bus.idx_valid !== 1'b1 || bus.idx !== IDXW'(4) || bus.idx_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second valid=%b idx=%0d last=%b expected 1 4 1", bus.idx_valid, bus.idx, bus.idx_last);
    end
    step();
    checks++;
    if (bus.idx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done valid=%b expected 0", bus.idx_valid);
    end
  endtask

  task automatic test_reset_mid_emit();
    bus.mask = 8'b0101_0100;
    bus.mask_valid = 1'b1;
    bus.idx_ready = 1'b1;
    step();
    bus.mask_valid = 1'b0;
    checks++;
    if (bus.idx_valid !== 1'b1 || bus.idx !== IDXW'(2)) begin
      errors++;
      $display("FAIL rst_mid_first valid=%b idx=%0d expected 1 2", bus.idx_valid, bus.idx);
    end
    step();
    checks++;
    if (bus.idx !== IDXW'(4)) begin
      errors++;
      $display("FAIL rst_mid_second idx=%0d expected 4", bus.idx);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.idx_valid !== 1'b0 || bus.idx !== '0 || bus.idx_last !== 1'b0 ||
        bus.mask_ready !== 1'b1 || bus.none_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async valid=%b idx=%0d last=%b ready=%b none=%b expected 0 0 0 1 0",
               bus.idx_valid, bus.idx, bus.idx_last, bus.mask_ready, bus.none_pulse);
    end
`ifdef MATCH_INDEX_SERIALIZER_COUNT_EN
    checks++;
    if (bus.match_cnt !== '0) begin
      errors++;
      $display("FAIL rst_mid_match_cnt got %0d expected 0", bus.match_cnt);
    end
`endif
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.idx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_residue valid=%b expected 0", bus.idx_valid);
    end
    run_mask(8'h02, 0, 0, "post_reset");
  endtask

  task automatic test_random();
    logic [SIZE-1:0] m;
    int sel, gap;
    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(9));
      if (sel == 0)      m = '0;
      else if (sel == 1) m = '1;
      else if (sel == 2) m = SIZE'(1) << $urandom_range(SIZE - 1);
      else               m = SIZE'($urandom);
      gap = int'($urandom_range(2));
      for (int g = 0; g < gap; g++) step();
      run_mask(m, int'($urandom_range(2)), int'($urandom_range(60)), "random");
    end
  endtask

  initial begin
    bus.mask_valid = 1'b0;
    bus.mask = '0;
    bus.idx_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_emit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
